i2c_slave_rx: RTL and testbench

//  I2C target (slave) receiver: the far end of the i2c_send master transmitter.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_sync_filter.sv | 48 ++++
 rtl/i2c_slave_rx.sv | 151 +++++++++++++++
 tb/tb_i2c_slave_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
// Optional build macro I2C_SLV_GCALL_EN is consumed by i2c_slave_rx.
package i2c_pkg;

    typedef logic [2:0] i2c_slv_state_t;

    localparam i2c_slv_state_t ST_IDLE     = 3'd0;
    localparam i2c_slv_state_t ST_ADDR     = 3'd1;
    localparam i2c_slv_state_t ST_ADDR_ACK = 3'd2;
    localparam i2c_slv_state_t ST_DATA     = 3'd3;
    localparam i2c_slv_state_t ST_DATA_ACK = 3'd4;
    localparam i2c_slv_state_t ST_IGNORE   = 3'd5;

    localparam logic [6:0] GCALL_ADDR = 7'h00;
    localparam logic       RW_WRITE   = 1'b0;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one I2C line.
// Filtered level moves only after FILT_LEN equal samples; edges are 1-cycle pulses.
module i2c_sync_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       s1;
    logic       s2;
    logic [3:0] cnt;
    logic       hit;

    assign hit = (s2 != level) && (cnt == 4'(FILT_LEN - 1));

    // synchronise, count disagreeing samples, commit level and emit edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= 4'd0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= hit && s2;
            fall <= hit && !s2;
            if (s2 == level) begin
                cnt <= 4'd0;
            end else if (hit) begin
                level <= s2;
                cnt   <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: START/STOP detect, address match, byte receive, ACK drive.
// Define I2C_SLV_GCALL_EN to also accept the general-call address 7'h00.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       busy,
    output logic       stop_det
);

    logic scl_lvl;
    logic scl_rise;
    logic scl_fall;
    logic sda_lvl;
    logic sda_rise;
    logic sda_fall;

    i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_slv_state_t state;
    logic [7:0]     shift;
    logic [2:0]     bit_cnt;
    logic           full;
    logic           first_pend;
    logic           start_c;
    logic           stop_c;
    logic           addr_ok;

    assign start_c = sda_fall && scl_lvl;
    assign stop_c  = sda_rise && scl_lvl;

`ifdef I2C_SLV_GCALL_EN
    assign addr_ok = (shift[0] == RW_WRITE) &&
                     ((shift[7:1] == SLV_ADDR) ||
                      (shift[7:1] == GCALL_ADDR));
`else
    assign addr_ok = (shift[0] == RW_WRITE) &&
                     (shift[7:1] == SLV_ADDR);
`endif

    // bus conditions override everything; otherwise step the byte/ack FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift      <= 8'd0;
            bit_cnt    <= 3'd0;
            full       <= 1'b0;
            first_pend <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            stop_det <= 1'b0;
            if (start_c) begin
                state   <= ST_ADDR;
                bit_cnt <= 3'd0;
                full    <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_c) begin
                state    <= ST_IDLE;
                full     <= 1'b0;
                sda_oe   <= 1'b0;
                stop_det <= busy;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    ST_ADDR, ST_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 3'd1;
                            full    <= (bit_cnt == 3'd7);
                        end else if (scl_fall && full) begin
                            full <= 1'b0;
                            if (state == ST_ADDR) begin
                                sda_oe <= addr_ok;
                                state  <= addr_ok ? ST_ADDR_ACK
                                                  : ST_IGNORE;
                            end else if (rx_ready) begin
                                sda_oe     <= 1'b1;
                                rx_data    <= shift;
                                rx_valid   <= 1'b1;
                                rx_first   <= first_pend;
                                first_pend <= 1'b0;
                                state      <= ST_DATA_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe     <= 1'b0;
                            busy       <= 1'b1;
                            first_pend <= 1'b1;
                            bit_cnt    <= 3'd0;
                            state      <= ST_DATA;
                        end
                    end
                    ST_DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= ST_DATA;
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: bus-level master model, vector table
// of write transactions, plus hand sequences for repeated START, glitches, reset.
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_ready = 1'b1;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       busy;
    logic       stop_det;

    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_rx #(.SLV_ADDR(7'h50), .FILT_LEN(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_m),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .busy     (busy),
        .stop_det (stop_det)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_stop = 0;
    int         n_oe = 0;
    logic [8:0] rxq[$];

    // record delivered bytes, stop pulses and ACK drive activity
    always @(negedge clk) begin
        if (rx_valid) rxq.push_back({rx_first, rx_data});
        if (stop_det) n_stop++;
        if (sda_oe) n_oe++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b0;
        tick(10);
    endtask

    task automatic rstart_c();
        scl_m = 1'b0; tick(5);
        sda_m = 1'b1; tick(5);
        scl_m = 1'b1; tick(5);
        sda_m = 1'b0; tick(10);
    endtask

    task automatic stop_c();
        scl_m = 1'b0; tick(5);
        sda_m = 1'b0; tick(5);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b1; tick(20);
    endtask

    task automatic bit_c(input logic b);
        scl_m = 1'b0; tick(5);
        sda_m = b;    tick(5);
        scl_m = 1'b1; tick(10);
    endtask

    task automatic gbit_c(input logic b);
        scl_m = 1'b0; tick(3);
        sda_m = b;    tick(2);
        scl_m = 1'b1; tick(2);
        scl_m = 1'b0; tick(3);
        scl_m = 1'b1; tick(3);
        sda_m = ~b;   tick(2);
        sda_m = b;    tick(5);
    endtask

    task automatic ack_c(output logic ack);
        scl_m = 1'b0; tick(5);
        sda_m = 1'b1; tick(5);
        scl_m = 1'b1; tick(8);
        ack = sda_oe;
        tick(2);
    endtask

    task automatic byte_c(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_c(b[i]);
        ack_c(ack);
    endtask

    typedef struct {
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       rdy;
        logic [2:0] ack;
        int         nrx;
        logic [8:0] rx0;
        logic [8:0] rx1;
        int         nstop;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] bs[3];
    logic [8:0] exp_rx[2];
    logic       ack;

    initial begin
        vecs[0] = '{3, 8'hA0, 8'h3C, 8'h5A, 1'b1, 3'b111, 2,
                    {1'b1, 8'h3C}, {1'b0, 8'h5A}, 1};
        vecs[1] = '{3, 8'hA0, 8'hFF, 8'h00, 1'b1, 3'b111, 2,
                    {1'b1, 8'hFF}, {1'b0, 8'h00}, 1};
        vecs[2] = '{2, 8'hA2, 8'h33, 8'h00, 1'b1, 3'b000, 0,
                    9'h0, 9'h0, 0};
        vecs[3] = '{3, 8'hA1, 8'h44, 8'h55, 1'b1, 3'b000, 0,
                    9'h0, 9'h0, 0};
        vecs[4] = '{2, 8'hA0, 8'h77, 8'h00, 1'b0, 3'b001, 0,
                    9'h0, 9'h0, 1};
        vecs[5] = '{2, 8'hA0, 8'h81, 8'h00, 1'b1, 3'b011, 1,
                    {1'b1, 8'h81}, 9'h0, 1};
`ifdef I2C_SLV_GCALL_EN
        vecs[6] = '{2, 8'h00, 8'h06, 8'h00, 1'b1, 3'b011, 1,
                    {1'b1, 8'h06}, 9'h0, 1};
`else
        vecs[6] = '{2, 8'h00, 8'h06, 8'h00, 1'b1, 3'b000, 0,
                    9'h0, 9'h0, 0};
`endif

        tick(4);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_first", 32'(rx_first), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stop_det", 32'(stop_det), 0);
        rst_n = 1'b1;
        tick(20);

        for (int v = 0; v < 7; v++) begin
            rx_ready = vecs[v].rdy;
            rxq.delete();
            n_stop = 0;
            n_oe = 0;
            bs[0] = vecs[v].b0;
            bs[1] = vecs[v].b1;
            bs[2] = vecs[v].b2;
            exp_rx[0] = vecs[v].rx0;
            exp_rx[1] = vecs[v].rx1;
            start_c();
            for (int k = 0; k < vecs[v].nb; k++) begin
                byte_c(bs[k], ack);
                check($sformatf("v%0d_ack%0d", v, k), 32'(ack),
                      32'(vecs[v].ack[k]));
            end
            check($sformatf("v%0d_busy", v), 32'(busy),
                  32'(vecs[v].ack[0]));
            stop_c();
            check($sformatf("v%0d_busy_end", v), 32'(busy), 0);
            check($sformatf("v%0d_nstop", v), 32'(n_stop),
                  32'(vecs[v].nstop));
            check($sformatf("v%0d_nrx", v), 32'(rxq.size()),
                  32'(vecs[v].nrx));
            if (vecs[v].ack == 3'b000)
                check($sformatf("v%0d_no_drive", v), 32'(n_oe), 0);
            for (int k = 0; k < vecs[v].nrx && k < rxq.size(); k++)
                check($sformatf("v%0d_rx%0d", v, k), 32'(rxq[k]),
                      32'(exp_rx[k]));
        end

        // repeated START mid-byte drops the partial byte
        rx_ready = 1'b1;
        rxq.delete();
        n_stop = 0;
        start_c();
        byte_c(8'hA0, ack);
        check("rs_ack_a", 32'(ack), 1);
        bit_c(1'b1); bit_c(1'b0); bit_c(1'b1); bit_c(1'b0);
        rstart_c();
        check("rs_nstop", 32'(n_stop), 0);
        check("rs_busy", 32'(busy), 0);
        byte_c(8'hA0, ack);
        check("rs_ack_b", 32'(ack), 1);
        byte_c(8'h11, ack);
        check("rs_ack_d", 32'(ack), 1);
        stop_c();
        check("rs_nrx", 32'(rxq.size()), 1);
        if (rxq.size() > 0) check("rs_rx", 32'(rxq[0]), 32'h111);
        check("rs_nstop_end", 32'(n_stop), 1);

        // 2-clk glitches on both lines inside every bit
        rxq.delete();
        n_stop = 0;
        start_c();
        byte_c(8'hA0, ack);
        for (int i = 7; i >= 0; i--) gbit_c(1'(8'hC3 >> i));
        ack_c(ack);
        check("gl_ack", 32'(ack), 1);
        stop_c();
        check("gl_nrx", 32'(rxq.size()), 1);
        if (rxq.size() > 0) check("gl_rx", 32'(rxq[0]), 32'h1C3);
        check("gl_nstop", 32'(n_stop), 1);

        // reset mid-byte, then recover on the next START
        rxq.delete();
        start_c();
        byte_c(8'hA0, ack);
        bit_c(1'b1); bit_c(1'b1); bit_c(1'b0); bit_c(1'b0);
        scl_m = 1'b0; tick(5);
        sda_m = 1'b1; tick(2);
        rst_n = 1'b0; tick(1);
        check("mr_sda_oe", 32'(sda_oe), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_rx_data", 32'(rx_data), 0);
        check("mr_rx_valid", 32'(rx_valid), 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        scl_m = 1'b1; tick(10);
        bit_c(1'b0); bit_c(1'b1);
        n_stop = 0;
        stop_c();
        check("mr_nstop", 32'(n_stop), 0);
        start_c();
        byte_c(8'hA0, ack);
        check("mr_ack_a", 32'(ack), 1);
        byte_c(8'h5A, ack);
        check("mr_ack_d", 32'(ack), 1);
        stop_c();
        check("mr_nrx", 32'(rxq.size()), 1);
        if (rxq.size() > 0) check("mr_rx", 32'(rxq[0]), 32'h15A);
        check("mr_nstop_end", 32'(n_stop), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
